io_intr_ctrl: RTL and testbench

- I/O and interrupt controller for the 16-bit basic computer.
- Owns the 8-bit input/output registers (INPR, OUTR), the flags FGI/FGO, the interrupt enable IEN and the pending flag R.
- Executes the register-I/O instructions INP, OUT, SKI, SKO, ION and IOF on behalf of the main controller.
- Sequences the three-cycle interrupt cycle (RT0-RT2) by driving bus-select and control strobes in the main controller's sequence-counter slots.

---
 rtl/io_pkg.sv | 50 +++++
 rtl/io_port.sv | 58 +++++
 rtl/io_intr_ctrl.sv | 172 +++++++++++++++++
 tb/tb_io_intr_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the basic-computer I/O and interrupt controller:
// bus source codes, io_op bit positions, FSM states and instruction decode.
package io_pkg;

  // Common-bus source codes driven during the interrupt cycle
  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_PC   = 3'b001;
  localparam logic [2:0] BUS_TR   = 3'b101;

  // Bit positions of the register-I/O instructions inside io_op (IR[11:6])
  localparam int OP_INP = 5;
  localparam int OP_OUT = 4;
  localparam int OP_SKI = 3;
  localparam int OP_SKO = 2;
  localparam int OP_ION = 1;
  localparam int OP_IOF = 0;

  // Interrupt sequencer states; PEND doubles as RT0 once sc_t0 arrives
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RT1  = 2'd2,
    ST_RT2  = 2'd3
  } state_t;

  // One-hot decoded I/O instruction
  typedef struct packed {
    logic inp;
    logic out;
    logic ski;
    logic sko;
    logic ion;
    logic iof;
  } io_dec_t;

  // Reduce io_op to a single instruction; the highest set bit wins so a
  // malformed opcode can never fire two actions in the same cycle.
  function automatic io_dec_t io_decode(input logic [5:0] op);
    io_dec_t d;
    d = '0;
    if (op[OP_INP])      d.inp = 1'b1;
    else if (op[OP_OUT]) d.out = 1'b1;
    else if (op[OP_SKI]) d.ski = 1'b1;
    else if (op[OP_SKO]) d.sko = 1'b1;
    else if (op[OP_ION]) d.ion = 1'b1;
    else if (op[OP_IOF]) d.iof = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/io_port.sv
// One side of the terminal interface: a status flag plus a DW-bit data
// register. The terminal side handshakes on hs_valid/hs_ready; the CPU side
// either takes the data (cpu_take) or loads new data (cpu_load).
// RX=1: a handshake captures hs_data and sets the flag (input side, INPR/FGI).
// RX=0: cpu_load captures cpu_data and clears the flag; a handshake only
//       sets the flag (output side, OUTR/FGO).
// When a set and a clear coincide the set wins, so a character arriving in
// the same cycle the CPU reads the previous one is never lost.
module io_port
  import io_pkg::*;
#(
  parameter int   DW       = 8,
  parameter bit   RX       = 1'b1,
  parameter logic FLAG_RST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs_valid,
  input  logic          hs_ready,
  input  logic [DW-1:0] hs_data,
  input  logic          cpu_take,
  input  logic          cpu_load,
  input  logic [DW-1:0] cpu_data,
  output logic          flag,
  output logic [DW-1:0] data
);

  logic          flag_reg, flag_next;
  logic [DW-1:0] data_reg, data_next;
  logic          hs_xfer;

  assign hs_xfer = hs_valid & hs_ready;

  // Next flag and data values: handshake sets, CPU access clears, set wins
  always_comb begin
    flag_next = flag_reg;
    data_next = data_reg;
    if (cpu_take || cpu_load) flag_next = 1'b0;
    if (hs_xfer)              flag_next = 1'b1;
    if (hs_xfer && RX)        data_next = hs_data;
    else if (cpu_load)        data_next = cpu_data;
  end

  // Flag and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg <= FLAG_RST;
      data_reg <= '0;
    end else begin
      flag_reg <= flag_next;
      data_reg <= data_next;
    end
  end

  assign flag = flag_reg;
  assign data = data_reg;

endmodule

// File: rtl/io_intr_ctrl.sv
// I/O and interrupt controller for the 16-bit basic computer. Executes the
// register-I/O instructions (INP, OUT, SKI, SKO, ION, IOF) and sequences the
// three-cycle interrupt cycle RT0-RT2 in the main controller's T0-T2 slots.
module io_intr_ctrl
  import io_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BUS_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sc_t0,
  input  logic             sc_t012,
  input  logic             io_exec,
  input  logic [5:0]       io_op,
  input  logic [DW-1:0]    ac_lo,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [DW-1:0]    inpr,
  output logic             ac_ld_inpr,
  output logic             pc_skip,
  output logic             intr_pend,
  output logic [BUS_W-1:0] bus_sel,
  output logic             ar_clr,
  output logic             tr_ld,
  output logic             mem_wr,
  output logic             pc_clr,
  output logic             pc_inr,
  output logic             sc_clr
);

  state_t  state_reg, state_next;
  logic    ien_reg, ien_next;
  logic    r_reg, r_next;
  logic    fgi, fgo;
  logic    io_ok;
  io_dec_t dec;
  logic    do_inp, do_out, do_ski, do_sko, do_ion, do_iof;

  // Instructions are honoured only while the main controller owns the bus;
  // during RT1/RT2 the interrupt sequencer drives it and io_exec is ignored.
  assign io_ok  = io_exec && (state_reg == ST_IDLE || state_reg == ST_PEND);
  assign dec    = io_decode(io_op);
  assign do_inp = io_ok & dec.inp;
  assign do_out = io_ok & dec.out;
  assign do_ski = io_ok & dec.ski;
  assign do_sko = io_ok & dec.sko;
  assign do_ion = io_ok & dec.ion;
  assign do_iof = io_ok & dec.iof;

  // Terminal handshakes: input accepts while FGI=0, output offers while FGO=0
  assign in_ready  = ~fgi;
  assign out_valid = ~fgo;

  // Input side: INPR/FGI. INP reads the current INPR and clears FGI.
  io_port #(
    .DW       (DW),
    .RX       (1'b1),
    .FLAG_RST (1'b0)
  ) u_in_port (
    .clk      (clk),
    .rst      (rst),
    .hs_valid (in_valid),
    .hs_ready (in_ready),
    .hs_data  (in_data),
    .cpu_take (do_inp),
    .cpu_load (1'b0),
    .cpu_data ({DW{1'b0}}),
    .flag     (fgi),
    .data     (inpr)
  );

  // Output side: OUTR/FGO. OUT loads OUTR from AC[7:0] and clears FGO.
  io_port #(
    .DW       (DW),
    .RX       (1'b0),
    .FLAG_RST (1'b1)
  ) u_out_port (
    .clk      (clk),
    .rst      (rst),
    .hs_valid (out_valid),
    .hs_ready (out_ready),
    .hs_data  ({DW{1'b0}}),
    .cpu_take (1'b0),
    .cpu_load (do_out),
    .cpu_data (ac_lo),
    .flag     (fgo),
    .data     (out_data)
  );

  assign ac_ld_inpr = do_inp;
  assign pc_skip    = (do_ski & fgi) | (do_sko & fgo);
  assign intr_pend  = r_reg;

  // Interrupt sequencer next state, IEN/R updates and interrupt-cycle strobes
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    ien_next   = ien_reg;
    bus_sel    = BUS_W'(BUS_NONE);
    ar_clr     = 1'b0;
    tr_ld      = 1'b0;
    mem_wr     = 1'b0;
    pc_clr     = 1'b0;
    pc_inr     = 1'b0;
    sc_clr     = 1'b0;

    if (do_ion)      ien_next = 1'b1;
    else if (do_iof) ien_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Only raise R outside T0-T2 so an instruction fetch is never split
        if (!sc_t012 && ien_reg && (fgi || fgo)) begin
          state_next = ST_PEND;
          r_next     = 1'b1;
        end
      end
      ST_PEND: begin
        // RT0: TR <- PC, AR <- 0
        if (sc_t0) begin
          bus_sel    = BUS_W'(BUS_PC);
          tr_ld      = 1'b1;
          ar_clr     = 1'b1;
          state_next = ST_RT1;
        end
      end
      ST_RT1: begin
        // M[0] <- TR (return address), PC <- 0
        bus_sel    = BUS_W'(BUS_TR);
        mem_wr     = 1'b1;
        pc_clr     = 1'b1;
        state_next = ST_RT2;
      end
      ST_RT2: begin
        // PC <- 1, SC <- 0; disabling IEN blocks immediate re-entry
        pc_inr     = 1'b1;
        sc_clr     = 1'b1;
        ien_next   = 1'b0;
        r_next     = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        r_next     = 1'b0;
      end
    endcase
  end

  // Sequencer state, IEN and R registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ien_reg   <= 1'b0;
      r_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ien_reg   <= ien_next;
      r_reg     <= r_next;
    end
  end

  // The main controller must not issue I/O instructions while it has yielded
  // the bus to the interrupt cycle.
  a_no_io_in_rt : assert property (@(posedge clk) disable iff (rst)
    !(io_exec && (state_reg == ST_RT1 || state_reg == ST_RT2)));

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Scoreboard bench for io_intr_ctrl: the stimulus process drives one cycle of
// inputs and pushes the hand-computed output snapshot for that cycle; the
// monitor pops and compares on the following falling edge.
module tb_io_intr_ctrl;

  localparam logic [5:0] OP_NONE = 6'b000000;
  localparam logic [5:0] OP_INP  = 6'b100000;
  localparam logic [5:0] OP_OUT  = 6'b010000;
  localparam logic [5:0] OP_SKI  = 6'b001000;
  localparam logic [5:0] OP_SKO  = 6'b000100;
  localparam logic [5:0] OP_ION  = 6'b000010;

  localparam logic [8:0] F_NONE  = 9'h000;
  localparam logic [8:0] F_ACLD  = 9'h100;
  localparam logic [8:0] F_SKIP  = 9'h080;
  localparam logic [8:0] F_PEND  = 9'h040;
  localparam logic [8:0] F_ARCLR = 9'h020;
  localparam logic [8:0] F_TRLD  = 9'h010;
  localparam logic [8:0] F_MEMWR = 9'h008;
  localparam logic [8:0] F_PCCLR = 9'h004;
  localparam logic [8:0] F_PCINR = 9'h002;
  localparam logic [8:0] F_SCCLR = 9'h001;

  localparam logic [8:0] F_RT0 = F_PEND | F_ARCLR | F_TRLD;
  localparam logic [8:0] F_RT1 = F_PEND | F_MEMWR | F_PCCLR;
  localparam logic [8:0] F_RT2 = F_PEND | F_PCINR | F_SCCLR;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] inpr;
    logic [2:0] bus_sel;
    logic [8:0] flags; // ac_ld, skip, pend, ar_clr, tr_ld, mem_wr, pc_clr, pc_inr, sc_clr
  } obs_t;

  logic       clk;
  logic       rst;
  logic       sc_t0, sc_t012, io_exec;
  logic [5:0] io_op;
  logic [7:0] ac_lo, in_data, out_data, inpr;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       ac_ld_inpr, pc_skip, intr_pend;
  logic [2:0] bus_sel;
  logic       ar_clr, tr_ld, mem_wr, pc_clr, pc_inr, sc_clr;

  obs_t  exp_q[$];
  string name_q[$];
  int    tests;
  int    fails;
  bit    stop;

  io_intr_ctrl #(.DW(8), .BUS_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .sc_t0      (sc_t0),
    .sc_t012    (sc_t012),
    .io_exec    (io_exec),
    .io_op      (io_op),
    .ac_lo      (ac_lo),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .inpr       (inpr),
    .ac_ld_inpr (ac_ld_inpr),
    .pc_skip    (pc_skip),
    .intr_pend  (intr_pend),
    .bus_sel    (bus_sel),
    .ar_clr     (ar_clr),
    .tr_ld      (tr_ld),
    .mem_wr     (mem_wr),
    .pc_clr     (pc_clr),
    .pc_inr     (pc_inr),
    .sc_clr     (sc_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic ir, input logic ov, input logic [7:0] od,
                              input logic [7:0] ip, input logic [2:0] bs,
                              input logic [8:0] fl);
    obs_t o;
    o.in_ready  = ir;
    o.out_valid = ov;
    o.out_data  = od;
    o.inpr      = ip;
    o.bus_sel   = bs;
    o.flags     = fl;
    return o;
  endfunction

  // Advance one clock and drive the inputs for the new cycle
  task automatic set_in(input logic r, input logic ex, input logic [5:0] op,
                        input logic [7:0] ac, input logic iv, input logic [7:0] id,
                        input logic ordy, input logic t0, input logic t012);
    @(posedge clk);
    #1;
    rst       = r;
    io_exec   = ex;
    io_op     = op;
    ac_lo     = ac;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    sc_t0     = t0;
    sc_t012   = t012;
  endtask

  task automatic expect_now(input string nm, input obs_t e);
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the current outputs against each queued expectation
  initial begin
    obs_t  e, a;
    string nm;
    tests = 0;
    fails = 0;
    while (!stop) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = mk(in_ready, out_valid, out_data, inpr, bus_sel,
               {ac_ld_inpr, pc_skip, intr_pend, ar_clr, tr_ld, mem_wr, pc_clr, pc_inr, sc_clr});
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s: got ir=%b ov=%b od=%h inpr=%h bus=%b fl=%b, want ir=%b ov=%b od=%h inpr=%h bus=%b fl=%b",
                   nm, a.in_ready, a.out_valid, a.out_data, a.inpr, a.bus_sel, a.flags,
                   e.in_ready, e.out_valid, e.out_data, e.inpr, e.bus_sel, e.flags);
        end else begin
          $display("[TB] %s ok", nm);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog in case the stimulus never completes
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Stimulus: directed cycles with hand-computed expected outputs
  initial begin
    stop      = 1'b0;
    rst       = 1'b1;
    io_exec   = 1'b0;
    io_op     = OP_NONE;
    ac_lo     = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    sc_t0     = 1'b0;
    sc_t012   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("reset_idle", mk(1, 0, 8'h00, 8'h00, 3'b000, F_NONE));
    set_in(0, 1, OP_SKO, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("sko_after_reset", mk(1, 0, 8'h00, 8'h00, 3'b000, F_SKIP));
    set_in(0, 1, OP_SKI, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("ski_fgi0", mk(1, 0, 8'h00, 8'h00, 3'b000, F_NONE));

    // Input handshake then INP
    set_in(0, 0, OP_NONE, 8'h00, 1, 8'h41, 0, 0, 0);
    expect_now("in_hs_41", mk(1, 0, 8'h00, 8'h00, 3'b000, F_NONE));
    set_in(0, 1, OP_SKI, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("ski_fgi1", mk(0, 0, 8'h00, 8'h41, 3'b000, F_SKIP));
    set_in(0, 1, OP_INP, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("inp_41", mk(0, 0, 8'h00, 8'h41, 3'b000, F_ACLD));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("after_inp", mk(1, 0, 8'h00, 8'h41, 3'b000, F_NONE));

    // INP and input handshake together: old data read, set wins
    set_in(0, 1, OP_INP, 8'h00, 1, 8'h77, 0, 0, 0);
    expect_now("inp_with_hs", mk(1, 0, 8'h00, 8'h41, 3'b000, F_ACLD));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("set_wins", mk(0, 0, 8'h00, 8'h77, 3'b000, F_NONE));
    set_in(0, 1, OP_INP, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("inp_77", mk(0, 0, 8'h00, 8'h77, 3'b000, F_ACLD));

    // OUT then output handshake
    set_in(0, 1, OP_OUT, 8'h5A, 0, 8'h00, 0, 0, 0);
    expect_now("out_5a", mk(1, 0, 8'h00, 8'h77, 3'b000, F_NONE));
    set_in(0, 1, OP_SKO, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("sko_fgo0", mk(1, 1, 8'h5A, 8'h77, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 1, 0, 0);
    expect_now("out_hs", mk(1, 1, 8'h5A, 8'h77, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("after_out_hs", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));

    // Non-one-hot opcodes: highest bit wins
    set_in(0, 1, OP_SKI | OP_SKO, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("prio_ski_over_sko", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));
    set_in(0, 1, OP_INP | OP_OUT, 8'hEE, 0, 8'h00, 0, 0, 0);
    expect_now("prio_inp_over_out", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_ACLD));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("no_out_load", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));

    // ION, blocked while sc_t012, then full interrupt cycle
    set_in(0, 1, OP_ION, 8'h00, 0, 8'h00, 0, 0, 1);
    expect_now("ion", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 1);
    expect_now("blocked_t012", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("pend_arm", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("pend", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_PEND));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 1, 1);
    expect_now("rt0", mk(1, 0, 8'h5A, 8'h77, 3'b001, F_RT0));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 1);
    expect_now("rt1", mk(1, 0, 8'h5A, 8'h77, 3'b101, F_RT1));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 1);
    expect_now("rt2", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_RT2));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("post_rt_idle", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));

    // No re-trigger (IEN cleared); OUT here also drops FGO for the next test
    set_in(0, 1, OP_OUT, 8'h33, 0, 8'h00, 0, 0, 0);
    expect_now("no_retrigger", mk(1, 0, 8'h5A, 8'h77, 3'b000, F_NONE));

    // Re-arm via FGI, then reset during RT1
    set_in(0, 1, OP_ION, 8'h00, 1, 8'h55, 0, 0, 1);
    expect_now("ion_with_in_hs", mk(1, 1, 8'h33, 8'h77, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("arm_by_fgi", mk(0, 1, 8'h33, 8'h55, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 1, 1);
    expect_now("rt0_b", mk(0, 1, 8'h33, 8'h55, 3'b001, F_RT0));
    set_in(1, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 1);
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 1);
    expect_now("reset_mid_rt", mk(1, 0, 8'h00, 8'h00, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("ien_cleared_a", mk(1, 0, 8'h00, 8'h00, 3'b000, F_NONE));
    set_in(0, 0, OP_NONE, 8'h00, 0, 8'h00, 0, 0, 0);
    expect_now("ien_cleared_b", mk(1, 0, 8'h00, 8'h00, 3'b000, F_NONE));

    @(posedge clk);
    #1 stop = 1'b1;
  end

endmodule
